// File: rtl/serial_alu_if.sv
// serial_alu_if: operation request / result bundle for serial_alu.
//
// Handshake: start is sampled only while busy=0 (IDLE or DONE). The rising
// edge that sees start=1 accepts the request and latches sel, a and b.
// busy is high for exactly WIDTH cycles after acceptance. done is a one-cycle
// pulse that arrives together with fresh y, cout and err. Those three hold
// until the next done. start during busy=1 is ignored.
interface serial_alu_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic             cout;
  logic             err;

  modport master (
    output start, sel, a, b,
    input  busy, done, y, cout, err
  );

  modport slave (
    input  start, sel, a, b,
    output busy, done, y, cout, err
  );
endinterface

// File: rtl/serial_alu.sv
// serial_alu: bit-serial ALU. It processes one bit per clock, LSB first,
// over WIDTH cycles. Logic ops are OR/AND/NOR/NAND.
// Optional macro SERIAL_ALU_ARITH_EN adds serial ADD (sel=100) and
// SUB (sel=101). Without it, every sel[2]=1 opcode is illegal and cout stays 0.
// The bus WIDTH parameter must match the interface instance WIDTH.
// dbg_state exposes the FSM state encoding: 0=IDLE, 1=RUN, 2=DONE.
module serial_alu #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_alu_if.slave        bus,
  output logic [1:0]         dbg_state
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sr;
  logic [2:0]       sel_q;
  logic [CW-1:0]    cnt;
  logic             res_bit;
  logic             illegal;
  logic             last;
`ifdef SERIAL_ALU_ARITH_EN
  logic             carry;
  logic             carry_nxt;
  logic             is_arith;
`endif

  assign dbg_state = state;
  assign last      = (cnt == CW'(WIDTH - 1));

`ifdef SERIAL_ALU_ARITH_EN
  assign illegal  = sel_q[2] & sel_q[1];
  assign is_arith = sel_q[2] & ~sel_q[1];
`else
  assign illegal  = sel_q[2];
`endif

  // Result bit (and ripple carry) for the current LSB of the shifting operands
  always_comb begin
    res_bit = 1'b0;
`ifdef SERIAL_ALU_ARITH_EN
    carry_nxt = 1'b0;
`endif
    case (sel_q)
      3'b000: res_bit = a_q[0] | b_q[0];
      3'b001: res_bit = a_q[0] & b_q[0];
      3'b010: res_bit = ~(a_q[0] | b_q[0]);
      3'b011: res_bit = ~(a_q[0] & b_q[0]);
`ifdef SERIAL_ALU_ARITH_EN
      3'b100: begin
        res_bit   = a_q[0] ^ b_q[0] ^ carry;
        carry_nxt = (a_q[0] & b_q[0]) | (carry & (a_q[0] ^ b_q[0]));
      end
      3'b101: begin
        res_bit   = a_q[0] ^ ~b_q[0] ^ carry;
        carry_nxt = (a_q[0] & ~b_q[0]) | (carry & (a_q[0] ^ ~b_q[0]));
      end
`endif
      default: res_bit = 1'b0;
    endcase
  end

  // Control FSM with registered busy/done and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.y    <= '0;
      bus.cout <= 1'b0;
      bus.err  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sr       <= '0;
      sel_q    <= 3'b000;
      cnt      <= '0;
`ifdef SERIAL_ALU_ARITH_EN
      carry    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            sel_q    <= bus.sel;
            cnt      <= '0;
`ifdef SERIAL_ALU_ARITH_EN
            // SUB is a + ~b + 1, so its carry-in starts at 1
            carry    <= (bus.sel == 3'b101);
`endif
            bus.busy <= 1'b1;
            state    <= RUN;
          end else begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        RUN: begin
          a_q <= a_q >> 1;
          b_q <= b_q >> 1;
          sr  <= {res_bit, sr[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
`ifdef SERIAL_ALU_ARITH_EN
          carry <= carry_nxt;
`endif
          if (last) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.err  <= illegal;
            bus.y    <= illegal ? '0 : {res_bit, sr[WIDTH-1:1]};
`ifdef SERIAL_ALU_ARITH_EN
            bus.cout <= is_arith & carry_nxt;
`else
            bus.cout <= 1'b0;
`endif
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu: directed vectors for serial_alu at WIDTH=8.
module tb_serial_alu;
  localparam int W = 8;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  serial_alu_if #(.WIDTH(W)) bus ();

  serial_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  int done_cnt;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_y;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one operation at the current negedge and follow it to DONE.
  // poke=1 pulses start with a=0 in the middle of RUN.
  task automatic run_op(input logic [2:0] s, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ey, input logic ec, input logic ee, input logic poke);
    logic [W-1:0] ey_q;
    exp_q.push_back(ey);
    bus.start = 1'b1;
    bus.sel   = s;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.start = 1'b0;
        bus.a     = ~av;
        bus.b     = ~bv;
        bus.sel   = ~s;
      end
      if (poke && i == 3) begin
        bus.start = 1'b1;
        bus.a     = '0;
      end
      if (poke && i == 4) bus.start = 1'b0;
      check($sformatf("run_busy[%0d]", i), bus.busy, 1'b1);
      check($sformatf("run_done[%0d]", i), bus.done, 1'b0);
      check($sformatf("run_y_hold[%0d]", i), bus.y, last_y);
    end
    @(negedge clk);
    ey_q = exp_q.pop_front();
    check("done_pulse", bus.done, 1'b1);
    check("done_busy", bus.busy, 1'b0);
    check("done_state", dbg_state, 2'd2);
    check("done_y", bus.y, ey_q);
    check("done_cout", bus.cout, ec);
    check("done_err", bus.err, ee);
    last_y = ey_q;
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, "_done_low"}, bus.done, 1'b0);
    check({tag, "_busy_low"}, bus.busy, 1'b0);
    check({tag, "_y_hold"}, bus.y, last_y);
  endtask

  initial begin
    int dc0;
    n_vec     = 0;
    n_err     = 0;
    done_cnt  = 0;
    last_y    = '0;
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.sel   = 3'b000;
    bus.a     = 8'h11;
    bus.b     = 8'h22;

    // reset beats a simultaneous start
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_y", bus.y, 8'h00);
    check("rst_cout", bus.cout, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("idle_state", dbg_state, 2'd0);

    // OR
    run_op(3'b000, 8'hA5, 8'h0F, 8'hAF, 1'b0, 1'b0, 1'b0);
    idle_check("or");

    // back-to-back NAND then NOR, second start issued during DONE
    run_op(3'b011, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0);
    run_op(3'b010, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    idle_check("nor");

    // AND with an ignored start pulse mid-run
    dc0 = done_cnt;
    run_op(3'b001, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b1);
    idle_check("and");
    check("and_one_done", done_cnt - dc0, 1);

    // reset in the 4th RUN cycle aborts the operation
    dc0 = done_cnt;
    bus.start = 1'b1;
    bus.sel   = 3'b000;
    bus.a     = 8'h12;
    bus.b     = 8'h34;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_y", bus.y, 8'h00);
    check("abort_cout", bus.cout, 1'b0);
    check("abort_err", bus.err, 1'b0);
    check("abort_state", dbg_state, 2'd0);
    last_y = '0;
    repeat (12) @(negedge clk);
    check("abort_no_done", done_cnt - dc0, 0);
    run_op(3'b011, 8'h3C, 8'h0F, 8'hF3, 1'b0, 1'b0, 1'b0);
    idle_check("post_abort");

`ifdef SERIAL_ALU_ARITH_EN
    run_op(3'b100, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
    run_op(3'b101, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0);
    run_op(3'b100, 8'h3A, 8'h45, 8'h7F, 1'b0, 1'b0, 1'b0);
    run_op(3'b101, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0, 1'b0);
    run_op(3'b110, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0);
    run_op(3'b111, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b1, 1'b0);
`else
    run_op(3'b100, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
    run_op(3'b111, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b1, 1'b0);
`endif
    // legal op after an illegal one clears err
    run_op(3'b010, 8'hA5, 8'h0F, 8'h50, 1'b0, 1'b0, 1'b0);
    idle_check("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
